// File: rtl/mem_boot_loader.sv
// mem_boot_loader
//   Loads a program image from a byte stream into the shared instruction/data
//   memory. The CPU is held in reset while the image is loaded. The loader then
//   verifies a trailing checksum byte and releases the CPU. The loader owns the
//   memory write port. It drives that port itself while loading, and passes the
//   CPU's address, write enable and write data straight through once running.
//
//   Parameters
//     WIDTH     data/address width; the memory is 2**WIDTH bytes
//     LOAD_LEN  image bytes per load (1..2**WIDTH), written to 0..LOAD_LEN-1
//     TIMEOUT   max idle cycles between accepted bytes in LOAD/CHECK (0 = off)
//
//   Ports
//     clk, reset            clock; synchronous active-low reset
//     load_req              requests a (re)load from IDLE, RUN or ERR
//     in_data/in_valid      byte stream input
//     in_ready              stream handshake; transfer = in_valid & in_ready
//     cpu_adr/cpu_memwrite/cpu_writedata
//                           CPU memory port, forwarded in RUN
//     cpu_reset             active-low CPU reset; high only in RUN
//     mem_adr/mem_we/mem_wd memory write port
//     busy                  high in LOAD or CHECK
//     error                 high in ERR
//     byte_count            image bytes accepted in the current/last load
module mem_boot_loader #(
  parameter int WIDTH    = 8,
  parameter int LOAD_LEN = 256,
  parameter int TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic             cpu_memwrite,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic             cpu_reset,
  output logic [WIDTH-1:0] mem_adr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wd,
  output logic             busy,
  output logic             error,
  output logic [WIDTH:0]   byte_count
);

  // The timer only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(LOAD_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERR} state_t;

  state_t           state;
  logic [WIDTH:0]   count;
  logic [WIDTH-1:0] sum;
  logic [TW-1:0]    timer;
  logic             xfer;
  logic             timeout_hit;

  assign in_ready   = (state == LOAD) || (state == CHECK);
  assign busy       = (state == LOAD) || (state == CHECK);
  assign error      = (state == ERR);
  assign cpu_reset  = (state == RUN);
  assign byte_count = count;

  assign xfer        = in_valid && in_ready;
  assign timeout_hit = (TIMEOUT != 0) && !xfer && (timer == TMAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      sum   <= '0;
      timer <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (load_req) begin
            state <= LOAD;
            count <= '0;
            sum   <= '0;
            timer <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            sum   <= sum + in_data;
            count <= count + 1'b1;
            timer <= '0;
            if (count == LAST) state <= CHECK;
          end else if (timeout_hit) begin
            state <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (xfer) begin
            state <= (in_data == sum) ? RUN : ERR;
            timer <= '0;
          end else if (timeout_hit) begin
            state <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port: the CPU owns it in RUN. Otherwise the loader presents the
  // next image address and writes only on an accepted LOAD transfer. The
  // checksum byte is consumed in CHECK and is never written.
  always_comb begin
    mem_adr = count[WIDTH-1:0];
    mem_wd  = in_data;
    mem_we  = (state == LOAD) && in_valid;
    if (state == RUN) begin
      mem_adr = cpu_adr;
      mem_wd  = cpu_writedata;
      mem_we  = cpu_memwrite;
    end
  end

endmodule

// File: tb/tb_mem_boot_loader.sv
module tb_mem_boot_loader;
  localparam int WIDTH    = 8;
  localparam int LOAD_LEN = 4;
  localparam int TIMEOUT  = 16;

  typedef logic [7:0] img_t [LOAD_LEN];

  logic       clk;
  logic       reset;
  logic       load_req;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] cpu_adr;
  logic       cpu_memwrite;
  logic [7:0] cpu_writedata;
  logic       cpu_reset;
  logic [7:0] mem_adr;
  logic       mem_we;
  logic [7:0] mem_wd;
  logic       busy;
  logic       error;
  logic [8:0] byte_count;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  mem_boot_loader #(.WIDTH(WIDTH), .LOAD_LEN(LOAD_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .load_req(load_req),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_adr(cpu_adr), .cpu_memwrite(cpu_memwrite), .cpu_writedata(cpu_writedata),
    .cpu_reset(cpu_reset), .mem_adr(mem_adr), .mem_we(mem_we), .mem_wd(mem_wd),
    .busy(busy), .error(error), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the loader.
  always @(posedge clk) if (mem_we) mem[mem_adr] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference checksum: plain sum of the image bytes, modulo 256.
  function automatic logic [7:0] ref_sum(input img_t img);
    int s;
    s = 0;
    for (int i = 0; i < LOAD_LEN; i++) s += int'(img[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit is_image, input int idx);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready", in_ready, 1);
    if (is_image) begin
      check("mem_we_load", mem_we, 1);
      check("mem_adr_load", mem_adr, idx);
      check("mem_wd_load", mem_wd, b);
      exp_mem[idx] = b;
    end else begin
      check("chk_not_written", mem_we, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_load(input img_t img, input logic [7:0] chk, input int gap, input bit hold_req);
    bit ok;
    load_req = 1'b1;
    tick();
    if (!hold_req) load_req = 1'b0;
    check("busy_on_load", busy, 1);
    check("cpu_held_load", cpu_reset, 0);
    check("count_cleared", byte_count, 0);
    for (int i = 0; i < LOAD_LEN; i++) begin
      repeat (gap) tick();
      check("byte_count_prog", byte_count, i);
      send_byte(img[i], 1'b1, i);
    end
    load_req = 1'b0;
    check("busy_in_check", busy, 1);
    repeat (gap) tick();
    send_byte(chk, 1'b0, 0);
    ok = (chk == ref_sum(img));
    check("cpu_reset_result", cpu_reset, ok);
    check("error_result", error, !ok);
    check("busy_after", busy, 0);
    check("byte_count_final", byte_count, LOAD_LEN);
    for (int i = 0; i < LOAD_LEN; i++) check("mem_content", mem[i], exp_mem[i]);
  endtask

  initial begin
    img_t img1;
    img_t img;
    logic [7:0] chk;
    logic [7:0] b0, b1;

    img1 = '{8'h01, 8'h02, 8'h03, 8'h04};
    reset = 1'b0; load_req = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    cpu_adr = 8'h00; cpu_memwrite = 1'b0; cpu_writedata = 8'h00;

    // Test 1: reset values, then a good load.
    repeat (2) tick();
    check("rst_cpu_reset", cpu_reset, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_byte_count", byte_count, 0);
    reset = 1'b1;
    tick();
    check("idle_cpu_held", cpu_reset, 0);
    do_load(img1, 8'h0A, 0, 1'b0);

    // Test 2: bad checksum, then recovery.
    do_load(img1, 8'h0B, 0, 1'b0);
    tick();
    check("err_sticky", error, 1);
    do_load(img1, 8'h0A, 0, 1'b0);

    // Test 3: gaps below the timeout, then a timeout after two bytes.
    do_load(img1, 8'h0A, 3, 1'b0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 1);
    repeat (TIMEOUT - 1) tick();
    check("no_timeout_yet", error, 0);
    check("still_busy", busy, 1);
    tick();
    check("timeout_error", error, 1);
    check("timeout_busy", busy, 0);
    check("timeout_count", byte_count, 2);
    check("timeout_cpu_held", cpu_reset, 0);

    // Test 4: passthrough in RUN, then reload.
    do_load(img1, 8'h0A, 1, 1'b0);
    cpu_adr = 8'h5A; cpu_memwrite = 1'b1; cpu_writedata = 8'hC3; load_req = 1'b1;
    @(negedge clk);
    check("pass_adr", mem_adr, 8'h5A);
    check("pass_we", mem_we, 1);
    check("pass_wd", mem_wd, 8'hC3);
    check("pass_cpu_run", cpu_reset, 1);
    @(posedge clk);
    #1;
    cpu_memwrite = 1'b0; load_req = 1'b0;
    check("reload_cpu_reset", cpu_reset, 0);
    check("reload_busy", busy, 1);
    check("reload_count", byte_count, 0);
    check("cpu_write_landed", mem[8'h5A], 8'hC3);
    check("loader_owns_adr", mem_adr, 0);

    // Test 5: reset mid-load, then a fresh load from address 0.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    send_byte(b0, 1'b1, 0);
    send_byte(b1, 1'b1, 1);
    reset = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_cpu", cpu_reset, 0);
    check("mid_rst_count", byte_count, 0);
    check("mid_rst_mem_adr", mem_adr, 0);
    check("mid_rst_mem_we", mem_we, 0);
    check("mem_kept0", mem[0], b0);
    check("mem_kept1", mem[1], b1);
    reset = 1'b1;
    tick();
    for (int i = 0; i < LOAD_LEN; i++) img[i] = 8'($urandom);
    do_load(img, ref_sum(img), 0, 1'b0);

    // Test 6: wrap-around checksum, load_req held high during the load.
    img = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load(img, 8'hFC, 0, 1'b1);

    // Randomized loads: random data, gaps, occasional corrupted checksum.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < LOAD_LEN; i++) img[i] = 8'($urandom);
      chk = ref_sum(img);
      if ($urandom_range(0, 1) == 1) chk = chk ^ 8'(1 << $urandom_range(0, 7));
      do_load(img, chk, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
